// File: rtl/geo_cmd_byte_packer.sv
// Packs Z80 lo/hi byte writes into 16-bit geometry commands,
// buffers them in a FIFO and drains one word per clock when not busy.
// Ports: clk, reset (sync, active-low); wr_lo/wr_hi/wr_data Z80 writes;
// cmd_flush, overflow_rst strobes; fifo_cmd_busy in; fifo_cmd_ready,
// fifo_cmd_in out; fill_level, fifo_full, fifo_empty, overflow_cnt status.
module geo_cmd_byte_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [7:0]       wr_data,
  input  logic             cmd_flush,
  input  logic             overflow_rst,
  input  logic             fifo_cmd_busy,
  output logic             fifo_cmd_ready,
  output logic [15:0]      fifo_cmd_in,
  output logic [CNT_W-1:0] fill_level,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [7:0]       overflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [7:0]       lo_q, lo_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             rdy_q, rdy_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             pop, push, drop;
  logic [15:0]      word;

  // Same-cycle lo+hi write forwards the new byte into both halves.
  assign word = {wr_data, wr_lo ? wr_data : lo_q};

  // Flush wins over both pop and push; a full FIFO still
  // accepts a word when the head leaves in the same cycle.
  assign pop  = !empty_q && !fifo_cmd_busy && !cmd_flush;
  assign push = wr_hi && !cmd_flush && (!full_q || pop);
  assign drop = wr_hi && !cmd_flush && full_q && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    rdy_d    = pop;
    cmd_d    = cmd_q;

    if (wr_lo) lo_d = wr_data;

    if (pop) begin
      cmd_d    = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);

    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CNT_W'(1);
      pop && !push: cnt_d = cnt_q - CNT_W'(1);
      default:      cnt_d = cnt_q;
    endcase

    if (cmd_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    // A drop coinciding with the clear is still counted.
    if (overflow_rst)
      ovf_d = {7'b0, drop};
    else if (drop && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;

    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      lo_q     <= 8'h00;
      ovf_q    <= 8'h00;
      rdy_q    <= 1'b0;
      cmd_q    <= 16'h0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      rdy_q    <= rdy_d;
      cmd_q    <= cmd_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end

  assign fifo_cmd_ready = rdy_q;
  assign fifo_cmd_in    = cmd_q;
  assign fill_level     = cnt_q;
  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign overflow_cnt   = ovf_q;

endmodule

// File: tb/tb_geo_cmd_byte_packer.sv
// Self-checking bench for geo_cmd_byte_packer: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_geo_cmd_byte_packer;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, wr_lo, wr_hi, cmd_flush, overflow_rst, fifo_cmd_busy;
  logic [7:0] wr_data;
  logic fifo_cmd_ready;
  logic [15:0] fifo_cmd_in;
  logic [CW-1:0] fill_level;
  logic fifo_full, fifo_empty;
  logic [7:0] overflow_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] issued[$];
  logic [7:0] m_lo = 8'h00;
  int m_ovf = 0;
  bit m_ready = 1'b0;
  logic [15:0] m_cmd = 16'h0000;

  always #5 clk = ~clk;

  geo_cmd_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_lo(wr_lo), .wr_hi(wr_hi),
    .wr_data(wr_data), .cmd_flush(cmd_flush),
    .overflow_rst(overflow_rst), .fifo_cmd_busy(fifo_cmd_busy),
    .fifo_cmd_ready(fifo_cmd_ready), .fifo_cmd_in(fifo_cmd_in),
    .fill_level(fill_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow_cnt(overflow_cnt)
  );

  task automatic model_step();
    bit pop, drop;
    logic [15:0] w;
    if (!reset) begin
      q.delete();
      m_lo = 8'h00; m_ovf = 0; m_ready = 1'b0; m_cmd = 16'h0000;
      return;
    end
    drop = 1'b0;
    w = {wr_data, wr_lo ? wr_data : m_lo};
    pop = (q.size() > 0) && !fifo_cmd_busy && !cmd_flush;
    if (cmd_flush) begin
      q.delete();
    end else begin
      if (pop) m_cmd = q.pop_front();
      if (wr_hi) begin
        if (q.size() < DEPTH) q.push_back(w);
        else drop = 1'b1;
      end
    end
    m_ready = pop;
    if (wr_lo) m_lo = wr_data;
    if (overflow_rst) m_ovf = drop ? 1 : 0;
    else if (drop && m_ovf < 255) m_ovf++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (fifo_cmd_ready === 1'b1) issued.push_back(fifo_cmd_in);
  endtask

  task automatic clr();
    wr_lo = 0; wr_hi = 0; cmd_flush = 0; overflow_rst = 0;
    wr_data = 8'h00;
  endtask

  task automatic test_reset();
    clr();
    reset = 0; fifo_cmd_busy = 0;
    wr_hi = 1; wr_data = 8'hAB;
    repeat (3) tick();
    checks++;
    if (fifo_cmd_ready !== 1'b0 || fifo_cmd_in !== 16'h0 ||
        fill_level !== '0 || overflow_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_out: rdy=%b cmd=%h fill=%0d ovf=%0d exp 0",
               fifo_cmd_ready, fifo_cmd_in, fill_level, overflow_cnt);
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b exp 1 0",
               fifo_empty, fifo_full);
    end
    reset = 1; wr_hi = 0;
    tick();
    checks++;
    if (fifo_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b exp 0", fifo_cmd_ready);
    end
  endtask

  task automatic test_single();
    clr(); fifo_cmd_busy = 0;
    wr_lo = 1; wr_data = 8'h34; tick();
    clr(); wr_hi = 1; wr_data = 8'h12; tick();
    clr();
    checks++;
    if (fifo_cmd_ready !== 1'b0 || fill_level !== CW'(1)) begin
      errors++;
      $display("FAIL single_t0: rdy=%b fill=%0d exp 0 1",
               fifo_cmd_ready, fill_level);
    end
    tick();
    checks++;
    if (fifo_cmd_ready !== 1'b1 || fifo_cmd_in !== 16'h1234 ||
        fill_level !== '0) begin
      errors++;
      $display("FAIL single_t1: rdy=%b cmd=%h fill=%0d exp 1 1234 0",
               fifo_cmd_ready, fifo_cmd_in, fill_level);
    end
    tick();
    checks++;
    if (fifo_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_t2: rdy=%b exp 0", fifo_cmd_ready);
    end
  endtask

  task automatic test_overflow();
    clr(); fifo_cmd_busy = 1;
    for (int i = 0; i < 17; i++) begin
      wr_lo = 1; wr_hi = 0; wr_data = 8'(i); tick();
      wr_lo = 0; wr_hi = 1; wr_data = 8'h01; tick();
    end
    clr();
    checks++;
    if (fifo_full !== 1'b1 || fill_level !== CW'(16) ||
        overflow_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_full: full=%b fill=%0d ovf=%0d exp 1 16 1",
               fifo_full, fill_level, overflow_cnt);
    end
    issued.delete();
    fifo_cmd_busy = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (fifo_cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL ovf_stream%0d: rdy=%b exp 1", i, fifo_cmd_ready);
      end
    end
    repeat (4) tick();
    checks++;
    if (issued.size() != 16) begin
      errors++;
      $display("FAIL ovf_count: got %0d words exp 16", issued.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (issued[i] !== 16'h0100 + 16'(i)) begin
          errors++;
          $display("FAIL ovf_order%0d: got %h exp %h",
                   i, issued[i], 16'h0100 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_ovf_sat();
    clr(); fifo_cmd_busy = 1;
    wr_hi = 1; wr_data = 8'h03;
    repeat (16) tick();
    overflow_rst = 1; tick();
    overflow_rst = 0;
    checks++;
    if (overflow_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_rst_drop: got %0d exp 1", overflow_cnt);
    end
    repeat (300) tick();
    checks++;
    if (overflow_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL ovf_sat: got %h exp ff", overflow_cnt);
    end
    clr(); overflow_rst = 1; tick();
    clr(); cmd_flush = 1; tick();
    clr();
    checks++;
    if (overflow_cnt !== 8'd0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%0d empty=%b exp 0 1",
               overflow_cnt, fifo_empty);
    end
  endtask

  task automatic test_wrap();
    clr(); fifo_cmd_busy = 1;
    wr_lo = 1; wr_data = 8'h5A; tick();
    clr();
    for (int k = 0; k < 16; k++) begin
      wr_hi = 1; wr_data = 8'(k); tick();
    end
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: full=%b exp 1", fifo_full);
    end
    issued.delete();
    fifo_cmd_busy = 0;
    for (int k = 16; k < 40; k++) begin
      wr_hi = 1; wr_data = 8'(k); tick();
      checks++;
      if (fill_level !== CW'(16) || overflow_cnt !== 8'd0) begin
        errors++;
        $display("FAIL wrap_k%0d: fill=%0d ovf=%0d exp 16 0",
                 k, fill_level, overflow_cnt);
      end
    end
    clr();
    repeat (20) tick();
    checks++;
    if (issued.size() != 40) begin
      errors++;
      $display("FAIL wrap_count: got %0d words exp 40", issued.size());
    end else begin
      for (int k = 0; k < 40; k++) begin
        checks++;
        if (issued[k] !== {8'(k), 8'h5A}) begin
          errors++;
          $display("FAIL wrap_order%0d: got %h exp %h",
                   k, issued[k], {8'(k), 8'h5A});
        end
      end
    end
  endtask

  task automatic test_flush();
    clr(); fifo_cmd_busy = 1;
    wr_lo = 1; wr_data = 8'h77; tick();
    clr();
    for (int i = 0; i < 5; i++) begin
      wr_hi = 1; wr_data = 8'h10 + 8'(i); tick();
    end
    checks++;
    if (fill_level !== CW'(5)) begin
      errors++;
      $display("FAIL flush_pre: fill=%0d exp 5", fill_level);
    end
    cmd_flush = 1; wr_hi = 1; wr_data = 8'h99; tick();
    clr();
    checks++;
    if (fill_level !== '0 || fifo_empty !== 1'b1 ||
        overflow_cnt !== 8'd0) begin
      errors++;
      $display("FAIL flush_post: fill=%0d empty=%b ovf=%0d exp 0 1 0",
               fill_level, fifo_empty, overflow_cnt);
    end
    fifo_cmd_busy = 0;
    issued.delete();
    repeat (5) tick();
    checks++;
    if (issued.size() != 0) begin
      errors++;
      $display("FAIL flush_nostrobe: got %0d words exp 0", issued.size());
    end
    wr_hi = 1; wr_data = 8'h42; tick();
    clr(); tick();
    checks++;
    if (fifo_cmd_ready !== 1'b1 || fifo_cmd_in !== 16'h4277) begin
      errors++;
      $display("FAIL flush_lo: rdy=%b cmd=%h exp 1 4277",
               fifo_cmd_ready, fifo_cmd_in);
    end
  endtask

  task automatic test_random();
    clr(); fifo_cmd_busy = 0;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      wr_lo = ($urandom_range(0, 2) == 0);
      wr_hi = ($urandom_range(0, 1) == 0);
      wr_data = 8'($urandom);
      cmd_flush = ($urandom_range(0, 63) == 0);
      overflow_rst = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 9) == 0) fifo_cmd_busy = ~fifo_cmd_busy;
      tick();
      checks++;
      if (fifo_cmd_ready !== m_ready || fifo_cmd_in !== m_cmd ||
          fill_level !== CW'(q.size()) ||
          fifo_full !== (q.size() == DEPTH) ||
          fifo_empty !== (q.size() == 0) ||
          overflow_cnt !== 8'(m_ovf)) begin
        errors++;
        $display("FAIL rand%0d: rdy=%b/%b cmd=%h/%h fill=%0d/%0d ful=%b emp=%b ovf=%0d/%0d",
                 n, fifo_cmd_ready, m_ready, fifo_cmd_in, m_cmd,
                 fill_level, q.size(), fifo_full, fifo_empty,
                 overflow_cnt, m_ovf);
      end
    end
    reset = 1;
    clr();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_ovf_sat();
    test_wrap();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
